// File: rtl/rx_lane_deskew.sv
// Four-lane receive deskew: per-lane tap delay lines aligned on the |A| character,
// with a hunt window FSM and loss-of-alignment monitoring.
module rx_lane_deskew #(
  parameter int unsigned MAX_SKEW   = 4,
  parameter int unsigned SKEW_W     = 3,
  parameter logic [7:0]  CHAR_A     = 8'h7C,
  parameter int unsigned LOSS_THRES = 4
) (
  input  logic                  i_unif_clk,
  input  logic                  i_unif_rst,
  input  logic [31:0]           i_l_data,
  input  logic [3:0]            i_l_datak,
  output logic [31:0]           o_u_data,
  output logic [3:0]            o_u_datak,
  output logic                  o_u_aligned,
  output logic [4*SKEW_W-1:0]   o_u_skew,
  output logic                  o_u_realign
);

  localparam int unsigned NTAP  = MAX_SKEW + 1;
  localparam int unsigned BAD_W = $clog2(LOSS_THRES + 1);

  typedef enum logic [1:0] {
    HUNT_IDLE,
    HUNT_WIN,
    ALIGNED
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       tap_data_q [NTAP];
  logic [3:0]        tap_k_q    [NTAP];
  logic [SKEW_W-1:0] w_q, w_d;
  logic [SKEW_W-1:0] off_q   [4];
  logic [SKEW_W-1:0] off_d   [4];
  logic [SKEW_W-1:0] delay_q [4];
  logic [SKEW_W-1:0] delay_d [4];
  logic [3:0]        seen_q, seen_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              loss;

  logic [3:0]        a_tap0;
  logic [3:0]        a_sel;
  logic [31:0]       sel_data;
  logic [3:0]        sel_k;

  logic [31:0]       data_q;
  logic [3:0]        datak_q;
  logic              aligned_q;
  logic              realign_q;

  always_comb begin
    a_tap0   = '0;
    a_sel    = '0;
    sel_data = '0;
    sel_k    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a_tap0[i]           = tap_k_q[0][i] && (tap_data_q[0][8*i +: 8] == CHAR_A);
      sel_data[8*i +: 8]  = tap_data_q[delay_q[i]][8*i +: 8];
      sel_k[i]            = tap_k_q[delay_q[i]][i];
      a_sel[i]            = tap_k_q[delay_q[i]][i] &&
                            (tap_data_q[delay_q[i]][8*i +: 8] == CHAR_A);
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    off_d   = off_q;
    delay_d = delay_q;
    seen_d  = seen_q;
    bad_d   = bad_q;
    loss    = 1'b0;
    case (state_q)
      HUNT_IDLE: begin
        if (|a_tap0) begin
          w_d    = '0;
          seen_d = a_tap0;
          for (int unsigned i = 0; i < 4; i++) begin
            if (a_tap0[i]) off_d[i] = '0;
          end
          // All lanes on the same cycle: zero skew, lock immediately.
          if (&a_tap0) begin
            for (int unsigned i = 0; i < 4; i++) delay_d[i] = '0;
            seen_d  = '0;
            bad_d   = '0;
            state_d = ALIGNED;
          end else begin
            state_d = HUNT_WIN;
          end
        end
      end
      HUNT_WIN: begin
        w_d = w_q + 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
          if (a_tap0[i] && !seen_q[i]) begin
            off_d[i]  = w_d;
            seen_d[i] = 1'b1;
          end
        end
        // The lane completing the window is the latest one, so w_d is max offset.
        if (&seen_d) begin
          for (int unsigned i = 0; i < 4; i++) delay_d[i] = w_d - off_d[i];
          seen_d  = '0;
          bad_d   = '0;
          state_d = ALIGNED;
        end else if (w_d == SKEW_W'(MAX_SKEW)) begin
          seen_d  = '0;
          state_d = HUNT_IDLE;
        end
      end
      ALIGNED: begin
        if (|a_sel) begin
          if (&a_sel) begin
            bad_d = '0;
          end else if (bad_q != BAD_W'(LOSS_THRES)) begin
            bad_d = bad_q + 1'b1;
          end
        end
        if (bad_d == BAD_W'(LOSS_THRES)) begin
          loss    = 1'b1;
          bad_d   = '0;
          seen_d  = '0;
          state_d = HUNT_IDLE;
        end
      end
      default: state_d = HUNT_IDLE;
    endcase
  end

  always_ff @(posedge i_unif_clk) begin
    if (i_unif_rst) begin
      state_q <= HUNT_IDLE;
      w_q     <= '0;
      seen_q  <= '0;
      bad_q   <= '0;
      for (int unsigned k = 0; k < NTAP; k++) begin
        tap_data_q[k] <= '0;
        tap_k_q[k]    <= '0;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        off_q[i]   <= '0;
        delay_q[i] <= '0;
      end
      data_q    <= '0;
      datak_q   <= '0;
      aligned_q <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      seen_q  <= seen_d;
      bad_q   <= bad_d;
      off_q   <= off_d;
      delay_q <= delay_d;
      tap_data_q[0] <= i_l_data;
      tap_k_q[0]    <= i_l_datak;
      for (int unsigned k = 1; k < NTAP; k++) begin
        tap_data_q[k] <= tap_data_q[k-1];
        tap_k_q[k]    <= tap_k_q[k-1];
      end
      // Outputs follow the current state, so lock shows one edge after the delays load.
      aligned_q <= (state_q == ALIGNED) && !loss;
      data_q    <= ((state_q == ALIGNED) && !loss) ? sel_data : '0;
      datak_q   <= ((state_q == ALIGNED) && !loss) ? sel_k    : '0;
      realign_q <= loss;
    end
  end

  always_comb begin
    o_u_skew = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_u_skew[i*SKEW_W +: SKEW_W] = delay_q[i];
    end
  end

  assign o_u_data    = data_q;
  assign o_u_datak   = datak_q;
  assign o_u_aligned = aligned_q;
  assign o_u_realign = realign_q;

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Scoreboard bench for rx_lane_deskew: directed skewed-lane streams with a
// per-lane delay model feeding an expected-word queue drained by a monitor.
module tb_rx_lane_deskew;

  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     l_data;
  logic [3:0]      l_datak;
  logic [31:0]     u_data;
  logic [3:0]      u_datak;
  logic            u_aligned;
  logic [4*SW-1:0] u_skew;
  logic            u_realign;

  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q[$];
  bit mon_en = 1'b0;

  logic [31:0] tx_w [64];
  logic [3:0]  tx_k [64];
  logic [7:0]  hd [4][128];
  logic        hk [4][128];
  int ska [4];
  int skb [4];
  int sw_n, rst_n, real_n;
  int s0, e0, s1, e1;
  int d0 [4];
  int d1 [4];

  always #5 clk = ~clk;

  rx_lane_deskew #(
    .MAX_SKEW  (4),
    .SKEW_W    (SW),
    .CHAR_A    (8'h7C),
    .LOSS_THRES(4)
  ) dut (
    .i_unif_clk (clk),
    .i_unif_rst (rst),
    .i_l_data   (l_data),
    .i_l_datak  (l_datak),
    .o_u_data   (u_data),
    .o_u_datak  (u_datak),
    .o_u_aligned(u_aligned),
    .o_u_skew   (u_skew),
    .o_u_realign(u_realign)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void tx_clear();
    for (int i = 0; i < 64; i++) begin
      tx_w[i] = '0;
      tx_k[i] = '0;
    end
  endfunction

  function automatic void tx_count(input int lo, input int hi);
    for (int idx = lo; idx <= hi; idx++) begin
      for (int l = 0; l < 4; l++) tx_w[idx][8*l +: 8] = 8'(4*idx + l);
      tx_k[idx] = '0;
    end
  endfunction

  function automatic void tx_a(input int idx, input logic [3:0] k);
    tx_w[idx] = {4{8'h7C}};
    tx_k[idx] = k;
  endfunction

  function automatic void setup(input int a0, input int a1, input int a2, input int a3);
    ska[0] = a0; ska[1] = a1; ska[2] = a2; ska[3] = a3;
    skb = ska;
    sw_n = 1000; rst_n = -1; real_n = -1;
    s0 = 1000; e0 = -1; s1 = 1000; e1 = -1;
    for (int l = 0; l < 4; l++) begin
      d0[l] = 0;
      d1[l] = 0;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    l_data = '0;
    l_datak = '0;
    @(posedge clk); #1;
    chk("rst_data",    64'(u_data),    64'(0));
    chk("rst_datak",   64'(u_datak),   64'(0));
    chk("rst_aligned", 64'(u_aligned), 64'(0));
    chk("rst_skew",    64'(u_skew),    64'(0));
    chk("rst_realign", 64'(u_realign), 64'(0));
    rst = 1'b0;
  endtask

  task automatic run(input int ncyc);
    logic [4*SW-1:0] skew_end;
    for (int n = 0; n < ncyc; n++) begin
      logic [31:0] d;
      logic [3:0]  k;
      logic [35:0] w;
      bit al0, al1, al;
      int sk, idx, dl;
      d = '0;
      k = '0;
      w = '0;
      for (int l = 0; l < 4; l++) begin
        sk  = (n >= sw_n) ? skb[l] : ska[l];
        idx = n - sk;
        if (idx >= 0 && idx < 64) begin
          d[8*l +: 8] = tx_w[idx][8*l +: 8];
          k[l]        = tx_k[idx][l];
        end
        hd[l][n] = (n == rst_n) ? 8'h00 : d[8*l +: 8];
        hk[l][n] = (n == rst_n) ? 1'b0  : k[l];
      end
      l_data  = d;
      l_datak = k;
      rst     = (n == rst_n);
      al0 = (n >= s0) && (n <= e0);
      al1 = (n >= s1) && (n <= e1);
      al  = al0 || al1;
      if (al) begin
        // Lane l reaches the output one edge after sitting in tap[delay].
        for (int l = 0; l < 4; l++) begin
          dl = al0 ? d0[l] : d1[l];
          w[8*l +: 8] = hd[l][n-1-dl];
          w[32+l]     = hk[l][n-1-dl];
        end
        exp_q.push_back(w);
      end
      @(posedge clk); #1;
      chk("aligned", 64'(u_aligned), 64'(al));
      chk("realign", 64'(u_realign), 64'(n == real_n));
      if (n == rst_n)
        chk("rst_mid_outputs", 64'({u_skew, u_realign, u_aligned, u_datak, u_data}), 64'(0));
    end
    rst = 1'b0;
    skew_end = '0;
    for (int l = 0; l < 4; l++) begin
      if (s1 < 1000)      skew_end[SW*l +: SW] = SW'(d1[l]);
      else if (s0 < 1000) skew_end[SW*l +: SW] = SW'(d0[l]);
    end
    chk("skew", 64'(u_skew), 64'(skew_end));
    do_reset();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (u_aligned === 1'b1) begin
        chk("expected_word_available", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) chk("out_word", 64'({u_datak, u_data}), 64'(exp_q.pop_front()));
      end else begin
        chk("idle_zero", 64'({u_datak, u_data}), 64'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    l_data = '0;
    l_datak = '0;
    do_reset();
    mon_en = 1'b1;

    // Zero skew: immediate lock, delays all zero.
    tx_clear(); tx_count(3, 17); tx_a(2, 4'hF); tx_a(12, 4'hF);
    setup(0, 0, 0, 0);
    s0 = 4; e0 = 17;
    run(18);

    // Lane offsets 0,1,2,3 -> delays 3,2,1,0.
    tx_clear(); tx_count(3, 30); tx_a(2, 4'hF);
    setup(0, 1, 2, 3);
    s0 = 7; e0 = 19; d0 = '{3, 2, 1, 0};
    run(20);

    // Lane3 five cycles late: window times out, never locks.
    tx_clear(); tx_count(3, 23); tx_a(2, 4'hF); tx_a(12, 4'hF);
    setup(0, 0, 0, 5);
    run(24);

    // One corrupted |A|, a good one, then three corrupted: no realign.
    tx_clear(); tx_count(3, 29); tx_a(2, 4'hF);
    tx_a(10, 4'b1101); tx_a(14, 4'hF);
    tx_a(18, 4'b1101); tx_a(21, 4'b1101); tx_a(24, 4'b1101);
    setup(1, 0, 2, 0);
    s0 = 6; e0 = 29; d0 = '{1, 2, 0, 2};
    run(30);

    // Skew changes to 2,0,1,0 while locked at zero skew: loss, then relock.
    tx_clear(); tx_count(3, 8); tx_count(29, 43);
    tx_a(2, 4'hF); tx_a(16, 4'hF); tx_a(19, 4'hF); tx_a(28, 4'hF);
    setup(0, 0, 0, 0);
    skb = '{2, 0, 1, 0}; sw_n = 12; real_n = 20;
    s0 = 4; e0 = 19;
    s1 = 32; e1 = 43; d1 = '{0, 2, 1, 2};
    run(44);

    // Reset in the middle of a hunt window, then a fresh |A| relocks.
    tx_clear(); tx_count(3, 29); tx_a(2, 4'hF); tx_a(20, 4'hF);
    setup(0, 1, 2, 3);
    rst_n = 4;
    s0 = 25; e0 = 29; d0 = '{3, 2, 1, 0};
    run(30);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
